memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Memory-side responder for the cache_control protocol. Serves instruction fetches (icache) and data reads/writes (dcache) from CPUS cores over one shared single-port RAM.
- Arbitrates requests, holds one transaction at a time against the RAM, and returns per-CPU wait/load responses.
- Sits between the per-core caches blocks and the RAM model at the top of the system.

Parameters:
CPUS, 2, number of requesting cores (1 or 2)
ADDR_W, 32, address/data word width (word_t)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  per-CPU instruction read request
iaddr  in  CPUS*32  per-CPU instruction address, CPU k at bits [32k+31:32k]
dREN  in  CPUS  per-CPU data read request
dWEN  in  CPUS  per-CPU data write request
daddr  in  CPUS*32  per-CPU data address
dstore  in  CPUS*32  per-CPU write data
iwait  out  CPUS  1 = instruction request not complete this cycle
dwait  out  CPUS  1 = data request not complete this cycle
iload  out  CPUS*32  instruction data per CPU
dload  out  CPUS*32  read data per CPU
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- FSM states: IDLE, SERVE.
- Reset (async, nRST=0), from any state including mid-SERVE:
  - state=IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0.
  - Grant registers cleared; rr pointer=0.
  - iwait and dwait all 1.
- iload/dload: every CPU slice is ramload, unconditionally and combinationally. Consumers sample only when their wait is 0.

Arbitration, evaluated in IDLE only:
- Data requests (dREN|dWEN) beat instruction requests.
- Within a class, round-robin starting at CPU rr; rr advances to winner+1 mod CPUS after each completed transaction.
- With CPUS=1, rr is a constant 0.
- If dWEN and dREN are both high for one CPU, it is a write.

Grant capture:
- On an IDLE cycle with any request, register cpu id, class (I/D), wen, address and store; next state SERVE.
- If no request, stay in IDLE with the RAM idle.

SERVE state:
- ramaddr/ramstore come from the grant registers.
- ramREN = ~wen. ramWEN = wen; for instruction grants, wen=0.
- When ramstate==ACCESS: the granted CPU's iwait or dwait (per class) is 0 combinationally in that cycle, and the FSM returns to IDLE at the next edge.
- FREE/BUSY: hold the request; all waits stay 1.
- ERROR: treat as BUSY; keep driving and retry until ACCESS.

Latency and ordering:
- Minimum latency: request visible at edge t, grant at edge t, wait low in cycle t+1 if ACCESS is returned immediately.
- One IDLE cycle separates back-to-back transactions.

Requester protocol and waits:
- A requester must hold its enable, address and data stable until its wait is low.
- If the granted enable drops during SERVE, abort: deassert ramREN/WEN combinationally, return to IDLE next edge, do not advance rr.
- Non-granted waits are always 1. At most one wait bit across all iwait/dwait is 0 in any cycle.

Widths:
- Addresses are passed unmodified; no alignment checks.

Test Plan:
- Reset mid-transaction: assert nRST=0 in SERVE while ramWEN=1 -> ramWEN=0, all waits 1 immediately, without waiting for a clock edge; after release, first request is served normally.
- Single CPU0 read: dREN=1, daddr=0x40, RAM gives BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles; dwait[0]=0 only in the ACCESS cycle, dload[0]=0xDEADBEEF.
- Priority: CPU0 iREN (iaddr=0x0) and CPU0 dWEN (daddr=0x80, dstore=0x1234) in the same cycle -> write served first (ramWEN=1, ramstore=0x1234), then the fetch after one IDLE cycle.
- Round-robin: both CPUs hold dREN continuously, RAM always ACCESS -> grants alternate CPU0, CPU1, CPU0…; each dwait low every 4th cycle; never two waits low together.
- ERROR retry: RAM returns ERROR 3 cycles then ACCESS -> request held throughout, exactly one completion, rr advances once.
- Abort: CPU1 drops iREN during BUSY -> ramREN=0 the same cycle, FSM IDLE next cycle, rr unchanged; a CPU0 request is granted next.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: memory-side responder for the cache_control protocol.
// Serves icache fetches and dcache reads/writes from CPUS cores over one
// shared single-port RAM, one transaction at a time.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | RAM idle; arbitrate and capture the winning request
// SERVE | drive the granted request to the RAM until ACCESS or abort
module memory_arbiter #(
   parameter int CPUS   = 2,
   parameter int ADDR_W = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [CPUS-1:0]        iREN,
   input  logic [CPUS*ADDR_W-1:0] iaddr,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS*ADDR_W-1:0] daddr,
   input  logic [CPUS*ADDR_W-1:0] dstore,
   output logic [CPUS-1:0]        iwait,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS*ADDR_W-1:0] iload,
   output logic [CPUS*ADDR_W-1:0] dload,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [ADDR_W-1:0]      ramaddr,
   output logic [ADDR_W-1:0]      ramstore,
   input  logic [ADDR_W-1:0]      ramload,
   input  logic [1:0]             ramstate
);

   localparam int ID_W = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {IDLE, SERVE} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_q;
   logic [ID_W-1:0]     gnt_cpu_q;
   logic                gnt_data_q;
   logic                gnt_wen_q;
   logic [ADDR_W-1:0]   gnt_addr_q;
   logic [ADDR_W-1:0]   gnt_store_q;

   logic                req_found;
   logic [ID_W-1:0]     req_cpu;
   logic                req_data;
   logic                req_wen;
   logic [ADDR_W-1:0]   req_addr;
   logic [ADDR_W-1:0]   req_store;

   logic                granted_en;
   logic                capture;
   logic                complete;
   logic [ID_W-1:0]     rr_next;

   // The RAM read data fans out to every core; consumers qualify it with their wait.
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

   // Round-robin pick starting at rr: any data request beats every fetch.
   always_comb begin
      int idx;
      idx       = 0;
      req_found = 1'b0;
      req_cpu   = '0;
      req_data  = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_store = '0;
      for (int k = 0; k < CPUS; k++) begin
         idx = (int'(rr_q) + k) % CPUS;
         if (!req_found && (dREN[idx] || dWEN[idx])) begin
            req_found = 1'b1;
            req_cpu   = ID_W'(idx);
            req_data  = 1'b1;
            // dREN and dWEN together is treated as a write
            req_wen   = dWEN[idx];
            req_addr  = daddr[idx*ADDR_W +: ADDR_W];
            req_store = dstore[idx*ADDR_W +: ADDR_W];
         end
      end
      for (int k = 0; k < CPUS; k++) begin
         idx = (int'(rr_q) + k) % CPUS;
         if (!req_found && iREN[idx]) begin
            req_found = 1'b1;
            req_cpu   = ID_W'(idx);
            req_data  = 1'b0;
            req_wen   = 1'b0;
            req_addr  = iaddr[idx*ADDR_W +: ADDR_W];
            req_store = '0;
         end
      end
   end

   // The granted requester is still asking; dropping the enable aborts the transaction.
   always_comb begin
      granted_en = 1'b0;
      if (gnt_data_q) begin
         granted_en = gnt_wen_q ? dWEN[gnt_cpu_q] : dREN[gnt_cpu_q];
      end else begin
         granted_en = iREN[gnt_cpu_q];
      end
   end

   // Next round-robin start: one past the core that just completed, wrapping.
   always_comb begin
      rr_next = '0;
      if (CPUS > 1 && gnt_cpu_q != ID_W'(CPUS - 1)) begin
         rr_next = gnt_cpu_q + 1'b1;
      end
   end

   // Next-state and RAM/wait outputs; waits default high, at most one drops on ACCESS.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      complete = 1'b0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      case (state_q)
         IDLE: begin
            if (req_found) begin
               capture = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            ramaddr  = gnt_addr_q;
            ramstore = gnt_store_q;
            if (!granted_en) begin
               state_d = IDLE;
            end else begin
               ramREN = ~gnt_wen_q;
               ramWEN = gnt_wen_q;
               // FREE, BUSY and ERROR all mean keep driving and retry
               if (ramstate == RAM_ACCESS) begin
                  complete = 1'b1;
                  state_d  = IDLE;
                  if (gnt_data_q) begin
                     dwait[gnt_cpu_q] = 1'b0;
                  end else begin
                     iwait[gnt_cpu_q] = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant registers: loaded once per transaction in IDLE, held through SERVE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         gnt_cpu_q   <= '0;
         gnt_data_q  <= 1'b0;
         gnt_wen_q   <= 1'b0;
         gnt_addr_q  <= '0;
         gnt_store_q <= '0;
      end else if (capture) begin
         gnt_cpu_q   <= req_cpu;
         gnt_data_q  <= req_data;
         gnt_wen_q   <= req_wen;
         gnt_addr_q  <= req_addr;
         gnt_store_q <= req_store;
      end
   end

   // Round-robin pointer moves only on a completed transaction, never on an abort.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_q <= '0;
      end else if (complete) begin
         rr_q <= rr_next;
      end
   end

endmodule
